// File: rtl/syncrst_pkg.sv
// syncrst_pkg: shared constants and helpers for the syncrst_* register family.
package syncrst_pkg;

    localparam logic SYNCRST_RST_BIT = 1'b0;
    localparam logic SYNCRST_VLD_RST = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/syncrst_pipe_stage.sv
// syncrst_pipe_stage: one clock-enabled, synchronously reset data+valid stage with valid clear.
module syncrst_pipe_stage
    import syncrst_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{SYNCRST_RST_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_i,
    input  logic             vld_i,
    output logic [WIDTH-1:0] q_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    // clr kills validity even when stalled; data still only moves on en
    always_comb begin
        data_d = en ? d_i : data_q;
        vld_d  = clr ? SYNCRST_VLD_RST : en ? vld_i : vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
            vld_q  <= SYNCRST_VLD_RST;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/syncrst_pipe.sv
// syncrst_pipe: DEPTH-stage stallable, flushable data+valid delay line.
// Define SYNCRST_PIPE_OCC_EN to add the occ port (count of valid stages).
module syncrst_pipe
    import syncrst_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{SYNCRST_RST_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic [WIDTH-1:0] q
`ifdef SYNCRST_PIPE_OCC_EN
    ,
    output logic [clog2(DEPTH+1)-1:0] occ
`endif
);

    logic [WIDTH-1:0] data_c [0:DEPTH];
    logic             vld_c  [0:DEPTH];

    assign data_c[0] = d;
    assign vld_c[0]  = in_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        syncrst_pipe_stage #(
            .WIDTH  (WIDTH),
            .RST_VAL(RST_VAL)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .clr  (flush),
            .d_i  (data_c[i]),
            .vld_i(vld_c[i]),
            .q_o  (data_c[i+1]),
            .vld_o(vld_c[i+1])
        );
    end

    assign q         = data_c[DEPTH];
    assign out_valid = vld_c[DEPTH];

`ifdef SYNCRST_PIPE_OCC_EN
    localparam int OCC_W = clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q, occ_d;

    // one sample enters and the last stage leaves on every enabled edge
    always_comb begin
        occ_d = flush ? '0 : en ? occ_q + OCC_W'(in_valid) - OCC_W'(out_valid) : occ_q;
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_syncrst_pipe.sv
// tb_syncrst_pipe: directed vector table on DEPTH=4 plus queue scoreboard on DEPTH=4 and DEPTH=1.
module tb_syncrst_pipe;

    logic       clk = 1'b0;
    logic       rst, en, flush, in_valid;
    logic [7:0] d;
    logic       ov4, ov1;
    logic [7:0] q4, q1;
`ifdef SYNCRST_PIPE_OCC_EN
    logic [2:0] occ4;
    logic       occ1;
`endif

    always #5 clk = ~clk;

    syncrst_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
        .out_valid(ov4), .q(q4)
`ifdef SYNCRST_PIPE_OCC_EN
        , .occ(occ4)
`endif
    );

    syncrst_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
        .out_valid(ov1), .q(q1)
`ifdef SYNCRST_PIPE_OCC_EN
        , .occ(occ1)
`endif
    );

    typedef struct {
        logic       r, e, f, v;
        logic [7:0] d;
        logic       eov;
        logic [7:0] eq;
        logic       cq;
        logic [2:0] eocc;
    } vec_t;

    vec_t       tv[$];
    logic [8:0] m4[$];
    logic [8:0] m1[$];
    int         checks = 0;
    int         failures = 0;
    logic       sb4 = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic add(input logic r, e, f, v, input logic [7:0] dd,
                       input logic eov, input logic [7:0] eq, input logic cq, input logic [2:0] eocc);
        tv.push_back('{r, e, f, v, dd, eov, eq, cq, eocc});
    endtask

    function automatic int pop4();
        int c = 0;
        foreach (m4[i]) c += int'(m4[i][8]);
        return c;
    endfunction

    function automatic int pop1();
        int c = 0;
        foreach (m1[i]) c += int'(m1[i][8]);
        return c;
    endfunction

    task automatic step(input logic r, e, f, v, input logic [7:0] dd);
        rst = r; en = e; flush = f; in_valid = v; d = dd;
        @(posedge clk);
        if (r) begin
            foreach (m4[i]) m4[i] = 9'h000;
            foreach (m1[i]) m1[i] = 9'h000;
        end else begin
            if (e) begin
                m4.push_front({v, dd}); void'(m4.pop_back());
                m1.push_front({v, dd}); void'(m1.pop_back());
            end
            if (f) begin
                foreach (m4[i]) m4[i][8] = 1'b0;
                foreach (m1[i]) m1[i][8] = 1'b0;
            end
        end
        #1;
        chk("sb1_ov", 32'(ov1), 32'(m1[$][8]));
        if (m1[$][8]) chk("sb1_q", 32'(q1), 32'(m1[$][7:0]));
`ifdef SYNCRST_PIPE_OCC_EN
        chk("sb1_occ", 32'(occ1), 32'(pop1()));
`endif
        if (sb4) begin
            chk("sb4_ov", 32'(ov4), 32'(m4[$][8]));
            if (m4[$][8]) chk("sb4_q", 32'(q4), 32'(m4[$][7:0]));
`ifdef SYNCRST_PIPE_OCC_EN
            chk("sb4_occ", 32'(occ4), 32'(pop4()));
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = 8'h00;
        for (int i = 0; i < 4; i++) m4.push_back(9'h000);
        m1.push_back(9'h000);
        // reset, including one with every other control asserted
        add(1,0,0,0,8'h00, 0,8'h00,1,0);
        add(1,1,1,1,8'h55, 0,8'h00,1,0);
        // stream 01..08
        add(0,1,0,1,8'h01, 0,8'h00,1,1);
        add(0,1,0,1,8'h02, 0,8'h00,1,2);
        add(0,1,0,1,8'h03, 0,8'h00,1,3);
        add(0,1,0,1,8'h04, 1,8'h01,1,4);
        add(0,1,0,1,8'h05, 1,8'h02,1,4);
        add(0,1,0,1,8'h06, 1,8'h03,1,4);
        add(0,1,0,1,8'h07, 1,8'h04,1,4);
        add(0,1,0,1,8'h08, 1,8'h05,1,4);
        // stall: FF sample lost, outputs frozen
        add(0,0,0,1,8'hFF, 1,8'h05,1,4);
        add(0,0,0,1,8'hFF, 1,8'h05,1,4);
        add(0,0,0,1,8'hFF, 1,8'h05,1,4);
        // bubbles: invalid data still loads
        add(0,1,0,0,8'hAA, 1,8'h06,1,3);
        add(0,1,0,1,8'hA1, 1,8'h07,1,3);
        add(0,1,0,0,8'hA2, 1,8'h08,1,2);
        add(0,1,0,1,8'hA3, 0,8'hAA,1,2);
        add(0,1,0,0,8'hA4, 1,8'hA1,1,2);
        add(0,1,0,1,8'hB0, 0,8'hA2,1,2);
        add(0,1,0,1,8'hB1, 1,8'hA3,1,3);
        // flush with en=1, three valid in flight
        add(0,1,1,1,8'hC0, 0,8'h00,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        // flush while stalled
        add(0,1,0,1,8'hD0, 0,8'h00,0,1);
        add(0,0,1,1,8'hEE, 0,8'h00,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        // reset mid-stream with en, flush, in_valid all high
        add(0,1,0,1,8'hE0, 0,8'h00,0,1);
        add(0,1,0,1,8'hE1, 0,8'h00,0,2);
        add(1,1,1,1,8'hE2, 0,8'h00,1,0);
        add(0,1,0,1,8'hF0, 0,8'h00,1,1);
        add(0,1,0,0,8'hF1, 0,8'h00,1,1);
        add(0,1,0,0,8'h00, 0,8'h00,1,1);
        add(0,1,0,0,8'h00, 1,8'hF0,1,1);
        add(0,1,0,0,8'h00, 0,8'hF1,1,0);

        @(negedge clk);
        foreach (tv[k]) begin
            step(tv[k].r, tv[k].e, tv[k].f, tv[k].v, tv[k].d);
            chk($sformatf("row%0d_ov", k), 32'(ov4), 32'(tv[k].eov));
            if (tv[k].cq) chk($sformatf("row%0d_q", k), 32'(q4), 32'(tv[k].eq));
`ifdef SYNCRST_PIPE_OCC_EN
            chk($sformatf("row%0d_occ", k), 32'(occ4), 32'(tv[k].eocc));
`endif
        end

        sb4 = 1'b1;
        for (int n = 0; n < 400; n++)
            step($urandom_range(99) < 2, $urandom_range(99) < 75, $urandom_range(99) < 5,
                 $urandom_range(99) < 60, 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
